// File: rtl/motor_reversing_starter_if.sv
// Panel-side signal bundle of the reversing starter: push-button/overload inputs
// and the contactor/lamp outputs.
interface motor_reversing_starter_if;
    logic I1;
    logic I2;
    logic I3;
    logic I4;
    logic I5;
    logic O1;
    logic O2;
    logic O3;
    logic O4;
    logic O5;

    modport master (
        output I1, I2, I3, I4, I5,
        input  O1, O2, O3, O4, O5
    );

    modport slave (
        input  I1, I2, I3, I4, I5,
        output O1, O2, O3, O4, O5
    );
endinterface

// File: rtl/motor_reversing_starter.sv
// Forward/reverse motor starter: synchronised and debounced buttons drive an FSM that
// keeps K1/K2 exclusive, inserts a dead-time between any de-energise and energise, and latches faults.
module motor_reversing_starter #(
    parameter int DB_TICKS = 500_000,
    parameter int DT_TICKS = 12_500_000
) (
    input  logic                      clk,
    input  logic                      rst,
    motor_reversing_starter_if.slave  bus
);

    localparam int DB_W = $clog2(DB_TICKS) + 1;
    localparam int DT_W = $clog2(DT_TICKS) + 1;

    // One-hot so every lamp/contactor output is a flop output with no decode glitch.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_RUN_F = 5'b00010,
        S_RUN_R = 5'b00100,
        S_DEAD  = 5'b01000,
        S_FAULT = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        T_NONE = 2'd0,
        T_F    = 2'd1,
        T_R    = 2'd2
    } tgt_t;

    logic [3:0]      w_pins;
    logic [3:0]      r_sync_p0;
    logic [3:0]      r_sync_p1;
    logic [3:0]      r_stable;
    logic [DB_W-1:0] r_db_cnt [4];

    state_t          r_state;
    tgt_t            r_tgt;
    logic [DT_W-1:0] r_dt_cnt;

    logic w_fwd;
    logic w_rev;
    logic w_stop;
    logic w_trip;
    tgt_t w_dead_tgt;
    logic w_unused;

    assign w_pins   = {bus.I4, bus.I3, bus.I2, bus.I1};
    assign w_unused = bus.I5;

    // Input stage: 2-flop synchroniser, then a level debouncer per input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_stable  <= '0;
            for (int k = 0; k < 4; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync_p0 <= w_pins;
            r_sync_p1 <= r_sync_p0;
            for (int k = 0; k < 4; k++) begin
                if (r_sync_p1[k] != r_stable[k]) begin
                    if (r_db_cnt[k] == DB_W'(DB_TICKS - 1)) begin
                        r_stable[k] <= r_sync_p1[k];
                        r_db_cnt[k] <= '0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                end
            end
        end
    end

    assign w_fwd  = r_stable[0] & ~r_stable[1];
    assign w_rev  = r_stable[1] & ~r_stable[0];
    assign w_stop = r_stable[2];
    assign w_trip = r_stable[3];

    // Target as it stands after this cycle's commands; STOP outranks a direction.
    always_comb begin
        w_dead_tgt = r_tgt;
        if (w_stop) begin
            w_dead_tgt = T_NONE;
        end else if (w_fwd) begin
            w_dead_tgt = T_F;
        end else if (w_rev) begin
            w_dead_tgt = T_R;
        end
    end

    // Control stage: FSM and dead-time counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_DEAD;
            r_tgt    <= T_NONE;
            r_dt_cnt <= '0;
        end else if (w_trip) begin
            r_state  <= S_FAULT;
            r_tgt    <= T_NONE;
            r_dt_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_stop) begin
                        if (w_fwd) begin
                            r_state <= S_RUN_F;
                        end else if (w_rev) begin
                            r_state <= S_RUN_R;
                        end
                    end
                end
                S_RUN_F: begin
                    if (w_stop || w_rev) begin
                        r_state  <= S_DEAD;
                        r_tgt    <= w_stop ? T_NONE : T_R;
                        r_dt_cnt <= '0;
                    end
                end
                S_RUN_R: begin
                    if (w_stop || w_fwd) begin
                        r_state  <= S_DEAD;
                        r_tgt    <= w_stop ? T_NONE : T_F;
                        r_dt_cnt <= '0;
                    end
                end
                S_DEAD: begin
                    if (r_dt_cnt == DT_W'(DT_TICKS - 1)) begin
                        r_dt_cnt <= '0;
                        r_tgt    <= T_NONE;
                        case (w_dead_tgt)
                            T_F:     r_state <= S_RUN_F;
                            T_R:     r_state <= S_RUN_R;
                            default: r_state <= S_IDLE;
                        endcase
                    end else begin
                        r_dt_cnt <= r_dt_cnt + DT_W'(1);
                        r_tgt    <= w_dead_tgt;
                    end
                end
                S_FAULT: begin
                    if (w_stop) begin
                        r_state  <= S_DEAD;
                        r_tgt    <= T_NONE;
                        r_dt_cnt <= '0;
                    end
                end
                default: begin
                    r_state  <= S_DEAD;
                    r_tgt    <= T_NONE;
                    r_dt_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.O1 = r_state[1];
    assign bus.O2 = r_state[2];
    assign bus.O3 = r_state[4];
    assign bus.O4 = r_state[3];
    assign bus.O5 = 1'b0;

endmodule

// File: tb/tb_motor_reversing_starter.sv
// Directed bench for the reversing starter with short debounce/dead-time settings.
module tb_motor_reversing_starter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    motor_reversing_starter_if bus ();

    motor_reversing_starter #(
        .DB_TICKS(4),
        .DT_TICKS(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       i1;
        logic       i2;
        logic       i3;
        logic       i4;
        int         cyc;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus.O5, bus.O4, bus.O3, bus.O2, bus.O1};
    endfunction

    task automatic set_in(input logic i1, input logic i2, input logic i3, input logic i4);
        bus.I1 = i1;
        bus.I2 = i2;
        bus.I3 = i3;
        bus.I4 = i4;
    endtask

    task automatic check_outs(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: O5..O1 got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Returns ticks until output bit idx reaches val, or -1 if the bound expires.
    task automatic wait_bit(input int idx, input logic val, input int limit, output int n);
        logic [4:0] o;
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            o = outs();
            if (o[idx] === val) begin
                n = k;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.O1 === 1'b1 && bus.O2 === 1'b1) begin
                errors++;
                $display("FAIL exclusive: O1=%b O2=%b both high at %0t", bus.O1, bus.O2, $time);
            end
        end
    end

    initial begin
        int n;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  3, 5'b00000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 20, 5'b00000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 30, 5'b00000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 20, 5'b00000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 20, 5'b00010};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 5'b00010};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 20, 5'b00000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 5'b00000};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,  8, 5'b00010};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12, 5'b01000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 5'b00001};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 20, 5'b00000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 5'b00000};

        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        bus.I5 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_outs("reset_outs", 5'b01000);
        mon_en = 1'b1;

        // Start-up dead-time, then forward start.
        rst = 1'b0;
        wait_bit(3, 1'b0, 30, n);
        check_int("startup_dead_len", n, 10);
        check_outs("startup_idle", 5'b00000);
        repeat (10) tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        wait_bit(0, 1'b1, 30, n);
        check_int("fwd_latency", n, 7);
        check_outs("run_f", 5'b00001);

        // Reversal F -> R through a full dead-time.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        wait_bit(0, 1'b0, 30, n);
        check_int("rev_fall_latency", n, 7);
        check_outs("rev_dead", 5'b01000);
        wait_bit(3, 1'b0, 30, n);
        check_int("rev_dead_len", n, 10);
        check_outs("run_r", 5'b00010);

        // STOP outranks a held REV.
        set_in(1'b0, 1'b1, 1'b1, 1'b0);
        wait_bit(1, 1'b0, 30, n);
        check_int("stop_fall_latency", n, 7);
        check_outs("stop_dead", 5'b01000);
        wait_bit(3, 1'b0, 30, n);
        check_int("stop_dead_len", n, 10);
        check_outs("stop_idle", 5'b00000);
        repeat (20) tick();
        check_outs("stop_no_rerise", 5'b00000);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();

        // Glitch, conflict and steady-state vectors.
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].i1, vecs[i].i2, vecs[i].i3, vecs[i].i4);
            repeat (vecs[i].cyc) tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Overload trip, latch, and STOP-acknowledged recovery.
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        check_outs("fault_pre_run", 5'b00001);
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        wait_bit(2, 1'b1, 30, n);
        check_int("fault_latency", n, 7);
        check_outs("fault_outs", 5'b00100);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        check_outs("fault_latched", 5'b00100);
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        wait_bit(2, 1'b0, 30, n);
        check_int("fault_clear_latency", n, 7);
        check_outs("fault_clear_dead", 5'b01000);
        wait_bit(3, 1'b0, 30, n);
        check_int("fault_dead_len", n, 10);
        check_outs("fault_idle", 5'b00000);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();

        // Retarget R -> F while the dead-time is running.
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        check_outs("retarget_pre_run", 5'b00001);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        wait_bit(0, 1'b0, 30, n);
        check_int("retarget_fall_latency", n, 7);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        wait_bit(3, 1'b0, 30, n);
        check_int("retarget_dead_len", n, 10);
        check_outs("retarget_run_f", 5'b00001);

        // Reset while running.
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_outs("rst_midrun", 5'b01000);
        rst = 1'b0;
        wait_bit(3, 1'b0, 30, n);
        check_int("rst_dead_len", n, 10);
        check_outs("rst_idle", 5'b00000);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
